// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: shares one word-wide memory port between instruction fetch
// and the load/store unit with round-robin fairness. Sub-word loads are
// extracted from the fetched word. Sub-word stores use read-modify-write.
// Alignment faults and out-of-region faults are reported with the ack.
module arm_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        ls_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_excpt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_RD, RMW_WR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic        last_ls;     // 1 when the LSU received the most recent grant
  logic        req_ls;      // owner of the transaction in flight
  logic        req_we;
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic [15:0] req_wdata;   // only the sub-word lanes are needed after grant
  logic        mem_we_q;

  logic        elig_if, elig_ls;
  logic        grant_if, grant_ls;
  logic [31:0] g_addr;
  logic        g_we;
  logic [1:0]  g_size;
  logic        g_fault;

  logic        fin;
  logic        fin_ls;
  logic        fin_fault;
  logic [31:0] fin_data;

  // Alignment rule: words on 4-byte, halfwords on 2-byte boundaries; size 11 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Big-endian lane select: byte offset 0 is the most significant byte.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'b00:   r = {24'h0, word[31:24]};
          2'b01:   r = {24'h0, word[23:16]};
          2'b10:   r = {24'h0, word[15:8]};
          default: r = {24'h0, word[7:0]};
        endcase
      end
      SZ_HALF: r = off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace one byte/half lane of the read word with the store data, keeping the rest.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'b00:   r[31:24] = wd[7:0];
          2'b01:   r[23:16] = wd[7:0];
          2'b10:   r[15:8]  = wd[7:0];
          default: r[7:0]   = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = wd;
        else        r[31:16] = wd;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // A pending write never lands on a reset edge.
  assign mem_we = mem_we_q & ~rst;

  // Round-robin grant in IDLE; a requester still seeing its own ack is not eligible.
  always_comb begin
    elig_if  = if_req & ~if_ack;
    elig_ls  = ls_req & ~ls_ack;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      grant_ls = elig_ls & (~elig_if | ~last_ls);
      grant_if = elig_if & ~grant_ls;
    end
    g_addr  = grant_ls ? ls_addr : if_addr;
    g_we    = grant_ls & ls_we;
    g_size  = grant_ls ? ls_size : SZ_WORD;
    g_fault = misaligned(g_size, g_addr[1:0]);
  end

  // Decide whether a transaction completes this cycle and what it reports.
  always_comb begin
    fin       = 1'b0;
    fin_ls    = req_ls;
    fin_fault = 1'b0;
    fin_data  = 32'h0;
    case (state)
      IDLE: begin
        fin_ls = grant_ls;
        if ((grant_if | grant_ls) && g_fault) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end
      end
      ACCESS: begin
        fin = 1'b1;
        if (mem_excpt)   fin_fault = 1'b1;
        else if (!req_we) fin_data = extract_lane(mem_rdata, req_size, req_off);
      end
      RMW_RD: begin
        if (mem_excpt) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end
      end
      RMW_WR: fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  // Sequencer FSM with registered acks, response data and memory-port drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_ls   <= 1'b1;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_fault  <= 1'b0;
      ls_fault  <= 1'b0;
      if_rdata  <= 32'h0;
      ls_rdata  <= 32'h0;
      mem_we_q  <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      if_ack <= fin & ~fin_ls;
      ls_ack <= fin & fin_ls;
      if (fin && !fin_ls) begin
        if_fault <= fin_fault;
        if_rdata <= fin_data;
      end
      if (fin && fin_ls) begin
        ls_fault <= fin_fault;
        ls_rdata <= fin_data;
      end
      case (state)
        IDLE: begin
          if (grant_if || grant_ls) begin
            last_ls   <= grant_ls;
            req_ls    <= grant_ls;
            req_we    <= g_we;
            req_size  <= g_size;
            req_off   <= g_addr[1:0];
            req_wdata <= ls_wdata[15:0];
            if (!g_fault) begin
              mem_addr <= {g_addr[31:2], 2'b00};
              if (g_we && g_size != SZ_WORD) begin
                state <= RMW_RD;
              end else begin
                state    <= ACCESS;
                mem_we_q <= g_we;
                if (g_we) mem_wdata <= ls_wdata;
              end
            end
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          state    <= IDLE;
        end
        RMW_RD: begin
          if (mem_excpt) begin
            state <= IDLE;
          end else begin
            mem_wdata <= merge_lane(mem_rdata, req_size, req_off, req_wdata);
            mem_we_q  <= 1'b1;
            state     <= RMW_WR;
          end
        end
        RMW_WR: begin
          mem_we_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed bench for arm_mem_arbiter with a small word memory model.
// Mapped region: 0x10000000-0x10000FFF; everything else raises mem_excpt.
module tb_arm_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_excpt;

  always #5 clk = ~clk;

  arm_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_fault(if_fault),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_excpt(mem_excpt)
  );

  // Memory model
  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_data = 32'h0;
  logic        mapped;

  assign mapped    = (mem_addr[31:12] == 20'h10000);
  assign mem_rdata = mapped ? mem[mem_addr[11:2]] : 32'h0;
  assign mem_excpt = ~mapped;

  always @(posedge clk) begin
    if (pre_en)               mem[pre_addr[11:2]] <= pre_data;
    else if (mem_we && mapped) mem[mem_addr[11:2]] <= mem_wdata;
  end

  int we_cnt  = 0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (mem_we)          we_cnt  <= we_cnt + 1;
    if (if_ack | ls_ack) ack_cnt <= ack_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request; lat counts cycles from the request cycle (0) to the ack cycle.
  task automatic do_op(input bit is_ls, input bit we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic flt);
    logic got;
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      got = is_ls ? ls_ack : if_ack;
    end
    if (!got) chk("ack_timeout", 32'(lat), 32'h0);
    rd  = is_ls ? ls_rdata : if_rdata;
    flt = is_ls ? ls_fault : if_fault;
    ls_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        flt;
    int          we0, ack0;
    logic [1:0]  exp_ack;

    rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
    ls_size = 0; ls_addr = 0; ls_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_ack",   {31'h0, if_ack},   32'h0);
    chk("rst_ls_ack",   {31'h0, ls_ack},   32'h0);
    chk("rst_if_fault", {31'h0, if_fault}, 32'h0);
    chk("rst_ls_fault", {31'h0, ls_fault}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_we",   {31'h0, mem_we},   32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Word store then word load
    do_op(1, 1, 2'b10, 32'h1000_0004, 32'hDEAD_BEEF, lat, rd, flt);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_fault", {31'h0, flt}, 32'h0);
    chk("wst_mem", mem[1], 32'hDEAD_BEEF);
    do_op(1, 0, 2'b10, 32'h1000_0004, 32'h0, lat, rd, flt);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_data", rd, 32'hDEAD_BEEF);
    chk("wld_fault", {31'h0, flt}, 32'h0);

    // Sub-word store and loads
    preload(32'h1000_0004, 32'h1122_3344);
    do_op(1, 1, 2'b00, 32'h1000_0006, 32'h0000_00AA, lat, rd, flt);
    chk("bst_lat", 32'(lat), 32'd3);
    chk("bst_fault", {31'h0, flt}, 32'h0);
    do_op(1, 0, 2'b10, 32'h1000_0004, 32'h0, lat, rd, flt);
    chk("bst_word", rd, 32'h1122_AA44);
    do_op(1, 0, 2'b00, 32'h1000_0006, 32'h0, lat, rd, flt);
    chk("bld_lat", 32'(lat), 32'd2);
    chk("bld_data", rd, 32'h0000_00AA);
    do_op(1, 0, 2'b01, 32'h1000_0004, 32'h0, lat, rd, flt);
    chk("hld_data", rd, 32'h0000_1122);
    do_op(1, 1, 2'b01, 32'h1000_0006, 32'hFFFF_BEEF, lat, rd, flt);
    chk("hst_lat", 32'(lat), 32'd3);
    chk("hst_mem", mem[1], 32'h1122_BEEF);
    do_op(1, 0, 2'b00, 32'h1000_0007, 32'h0, lat, rd, flt);
    chk("bld3_data", rd, 32'h0000_00EF);
    do_op(1, 0, 2'b00, 32'h1000_0004, 32'h0, lat, rd, flt);
    chk("bld0_data", rd, 32'h0000_0011);

    // Alignment faults: ack in cycle 1, never a write
    we0 = we_cnt;
    do_op(1, 0, 2'b10, 32'h1000_0002, 32'h0, lat, rd, flt);
    chk("mis_w_lat", 32'(lat), 32'd1);
    chk("mis_w_fault", {31'h0, flt}, 32'h1);
    do_op(1, 0, 2'b01, 32'h1000_0001, 32'h0, lat, rd, flt);
    chk("mis_h_lat", 32'(lat), 32'd1);
    chk("mis_h_fault", {31'h0, flt}, 32'h1);
    do_op(1, 0, 2'b11, 32'h1000_0000, 32'h0, lat, rd, flt);
    chk("sz11_lat", 32'(lat), 32'd1);
    chk("sz11_fault", {31'h0, flt}, 32'h1);
    do_op(1, 1, 2'b10, 32'h1000_0005, 32'h1234_5678, lat, rd, flt);
    chk("mis_st_fault", {31'h0, flt}, 32'h1);
    chk("mis_no_we", 32'(we_cnt - we0), 32'h0);
    chk("mis_st_mem", mem[1], 32'h1122_BEEF);

    // Fetch: mapped, then unmapped
    do_op(0, 0, 2'b10, 32'h1000_0004, 32'h0, lat, rd, flt);
    chk("if_lat", 32'(lat), 32'd2);
    chk("if_data", rd, 32'h1122_BEEF);
    chk("if_fault0", {31'h0, flt}, 32'h0);
    do_op(0, 0, 2'b10, 32'h0000_0200, 32'h0, lat, rd, flt);
    chk("if_ex_fault", {31'h0, flt}, 32'h1);
    chk("if_ex_data", rd, 32'h0);

    // Byte store to unmapped region: fault after RMW_RD, no write
    we0 = we_cnt;
    do_op(1, 1, 2'b00, 32'h2000_0000, 32'h0000_0055, lat, rd, flt);
    chk("bst_ex_lat", 32'(lat), 32'd2);
    chk("bst_ex_fault", {31'h0, flt}, 32'h1);
    chk("bst_ex_no_we", 32'(we_cnt - we0), 32'h0);

    // Contention: both held from reset, grants alternate fetch/LSU
    preload(32'h1000_0000, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h1000_0004;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h1000_0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp_ack = {(i % 4 == 2), (i % 4 == 0)};
      chk($sformatf("rr_cyc%0d", i), {30'h0, if_ack, ls_ack}, {30'h0, exp_ack});
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("rr_if_data", if_rdata, 32'h1122_BEEF);
    chk("rr_ls_data", ls_rdata, 32'hCAFE_F00D);
    repeat (4) @(posedge clk);

    // Reset during RMW_RD of a byte store
    preload(32'h1000_0008, 32'h5566_7788);
    @(posedge clk); #1;
    we0  = we_cnt;
    ack0 = ack_cnt;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h1000_0009; ls_wdata = 32'h99;
    @(posedge clk); #1;
    rst = 1'b1;
    ls_req = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ls_ack",   {31'h0, ls_ack},   32'h0);
    chk("mrst_mem_we",   {31'h0, mem_we},   32'h0);
    chk("mrst_mem_addr", mem_addr, 32'h0);
    chk("mrst_mem_wdata", mem_wdata, 32'h0);
    chk("mrst_ls_rdata", ls_rdata, 32'h0);
    chk("mrst_if_rdata", if_rdata, 32'h0);
    chk("mrst_faults",   {30'h0, if_fault, ls_fault}, 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_we",  32'(we_cnt - we0), 32'h0);
    chk("mrst_no_ack", 32'(ack_cnt - ack0), 32'h0);
    chk("mrst_mem",    mem[2], 32'h5566_7788);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_mem_arbiter.md
# arm_mem_arbiter

Single-port memory arbiter and access sequencer between the instruction-fetch unit and the load/store unit (LSU). It shares one port of the two-port byte-addressed big-endian word memory between both requesters with round-robin fairness. It also adds byte/halfword access on top of the word-only memory port: sub-word loads by extraction, sub-word stores by read-modify-write. Alignment and memory-region faults are reported back to the requester.

## Interface

No parameters: address/data width fixed at 32, memory port is word-only.

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address (word access, read-only)
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word, valid with if_ack
- if_fault  out  1  fetch faulted, valid with if_ack
- ls_req  in  1  LSU request; held until ls_ack
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ls_ack  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data, zero-extended, right-aligned; valid with ls_ack
- ls_fault  out  1  LSU access faulted, valid with ls_ack
- mem_addr  out  32  word-aligned address to memory port ({addr[31:2],2'b00})
- mem_wdata  out  32  write word to memory port
- mem_we  out  1  memory write enable; memory writes at posedge when high
- mem_rdata  in  32  combinational read data from memory port
- mem_excpt  in  1  combinational out-of-region flag from memory port

## Operation

- States: IDLE, ACCESS, RMW_RD, RMW_WR.
- IDLE: a requester whose ack is high this cycle is ignored.
  - If exactly one of if_req/ls_req is eligible, grant it.
  - If both are eligible, grant the one not granted last. The last-grant pointer resets to LSU, so fetch wins the first tie.
  - The granted request (addr, we, size, wdata, id) is latched.
- Alignment check at grant:
  - A word access with addr[1:0]≠0, a halfword access with addr[0]≠0, or size 11 is a fault.
  - Fault → no memory cycle; ack+fault are registered directly (state stays IDLE).
- Grant of a load, a fetch or a word store → ACCESS. Grant of a byte/halfword store → RMW_RD.
- ACCESS: drive mem_addr.
  - Read: capture mem_rdata into the output register; for sub-word loads extract and zero-extend.
  - Word store: mem_we=1, mem_wdata=wdata.
  - mem_excpt=1 → fault=1, rdata=0.
  - Next state IDLE; ack pulses in that IDLE cycle.
- Byte/halfword extraction (big-endian): byte offset k selects mem_rdata[31-8k -: 8]. Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- RMW_RD: drive mem_addr with mem_we=0 and capture mem_rdata.
  - mem_excpt=1 → fault ack, go to IDLE, no write.
  - Else → RMW_WR.
- RMW_WR: mem_we=1. mem_wdata is the captured word with the target byte/half lane replaced by wdata[7:0]/[15:0]; all other lanes are unchanged. Then → IDLE with ack.
- mem_we=0 in all states except ACCESS (word store) and RMW_WR. mem_we is gated by !rst so no write lands on a reset edge.
- The non-granted requester waits; its inputs are not sampled.

## Timing

- Request seen in IDLE at cycle 0:
  - Fetch, load or word store: ack in cycle 2.
  - Sub-word store: ack in cycle 3.
  - Alignment fault: ack in cycle 1.
- Write lands at the posedge ending ACCESS (word) or RMW_WR (sub-word).
- ack, rdata and fault are registered; rdata/fault hold until the next ack to the same requester.
- Back-to-back: the cycle after ack is IDLE again; a held request from the other requester is granted then.
- Reset values: state IDLE, if_ack=ls_ack=0, if_fault=ls_fault=0, if_rdata=ls_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, pointer=LSU.
- Reset mid-operation: the transaction is dropped silently, with no ack and no partial write. The requester re-issues after reset.

## Test plan

- Word store ls_addr=0x10000004, wdata=0xDEADBEEF, then word load at the same address → ls_ack in cycle 2 of each; rdata=0xDEADBEEF.
- Byte store 0xAA at 0x10000006 over 0x11223344 → ack cycle 3; word read gives 0x1122AA44. Byte load at 0x10000006 gives 0x000000AA. Halfword load at 0x10000004 gives 0x00001122.
- if_req and ls_req both held continuously from reset → grants alternate fetch, LSU, fetch, …; each ack occurs every 2 cycles; neither requester is starved.
- Misaligned word load at 0x10000002, halfword at 0x10000001, size 11 → ack+fault in cycle 1; mem_we never asserted.
- Fetch at 0x00000200 (unmapped, mem_excpt=1) → if_ack, if_fault=1, rdata=0. Byte store to 0x20000000 → fault after RMW_RD; mem_we never high.
- rst asserted during RMW_RD of a byte store → no mem_we pulse, no ack; all outputs equal their reset values the next cycle; the memory word is unchanged.
